// File: rtl/mmio_periph.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mmio_periph
// Brief   : Memory-mapped LED/LCD/HEX outputs, synchronised switches, debounced
//           buttons with sticky edge flags and a free-running cycle timer.
//           Optional macro HEX_DECODE_EN: HEX registers hold {blank, nibble}.
// Revision: 1.0
// ============================================================================
module mmio_periph #(
  parameter int NUM_HEX    = 8,
  parameter int LEDR_W     = 17,
  parameter int LEDG_W     = 8,
  parameter int SW_W       = 18,
  parameter int BTN_W      = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [11:0]          i_addr,
  input  logic [31:0]          i_wdata,
  input  logic [3:0]           i_be,
  input  logic                 i_wren,
  input  logic                 i_rden,
  output logic [31:0]          o_rdata,
  output logic                 o_rvld,
  output logic                 o_err,
  input  logic [SW_W-1:0]      i_io_sw,
  input  logic [BTN_W-1:0]     i_io_btn,
  output logic [LEDR_W-1:0]    o_io_ledr,
  output logic [LEDG_W-1:0]    o_io_ledg,
  output logic [31:0]          o_io_lcd,
  output logic [NUM_HEX*7-1:0] o_io_hex
);

`ifdef HEX_DECODE_EN
  localparam int                 c_hex_w   = 5;
  localparam logic [c_hex_w-1:0] c_hex_rst = 5'h10;
`else
  localparam int                 c_hex_w   = 7;
  localparam logic [c_hex_w-1:0] c_hex_rst = 7'h7F;
`endif
  localparam int                 c_cnt_w   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES - 1);

  localparam logic [9:0] c_w_ledr  = 10'd0;
  localparam logic [9:0] c_w_ledg  = 10'd1;
  localparam logic [9:0] c_w_lcd   = 10'd2;
  localparam logic [9:0] c_w_edge  = 10'd3;
  localparam logic [9:0] c_w_sw    = 10'd4;
  localparam logic [9:0] c_w_btn   = 10'd5;
  localparam logic [9:0] c_w_timer = 10'd6;
  localparam int         c_w_hex0  = 16;

  logic [LEDR_W-1:0]                   ledr_q, ledr_d;
  logic [LEDG_W-1:0]                   ledg_q, ledg_d;
  logic [31:0]                         lcd_q, lcd_d;
  logic [31:0]                         timer_q, timer_d;
  logic [NUM_HEX-1:0][c_hex_w-1:0]     hex_q, hex_d;
  logic [SW_W-1:0]                     sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [BTN_W-1:0]                    btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [BTN_W-1:0]                    lvl_q, lvl_d;
  logic [BTN_W-1:0]                    edge_q, edge_d;
  logic [BTN_W-1:0][c_cnt_w-1:0]       cnt_q, cnt_d;
  logic [31:0]                         rdata_q, rdata_d;
  logic                                rvld_q, rvld_d;
  logic                                err_q, err_d;

  logic [9:0]         w_word;
  logic [NUM_HEX-1:0] w_hex_sel;
  logic               w_mapped;
  logic [31:0]        w_rdata;
  logic [BTN_W-1:0]   w_edge_clr;
  logic               w_unused;

  assign w_word   = i_addr[11:2];
  assign w_unused = ^i_addr[1:0];

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int l = 0; l < 4; l++) begin
      if (be[l]) r[8*l +: 8] = wd[8*l +: 8];
    end
    return r;
  endfunction

`ifdef HEX_DECODE_EN
  function automatic logic [6:0] f_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return s;
  endfunction
`endif

  always_comb begin
    w_hex_sel = '0;
    for (int k = 0; k < NUM_HEX; k++) begin
      w_hex_sel[k] = (w_word == 10'(c_w_hex0 + k));
    end
    w_mapped = (w_word <= c_w_timer) || (|w_hex_sel);
  end

  // Read mux sees pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    w_rdata = '0;
    case (w_word)
      c_w_ledr:  w_rdata = 32'(ledr_q);
      c_w_ledg:  w_rdata = 32'(ledg_q);
      c_w_lcd:   w_rdata = lcd_q;
      c_w_edge:  w_rdata = 32'(edge_q);
      c_w_sw:    w_rdata = 32'(sw_s2_q);
      c_w_btn:   w_rdata = 32'(lvl_q);
      c_w_timer: w_rdata = timer_q;
      default: begin
        for (int k = 0; k < NUM_HEX; k++) begin
          if (w_hex_sel[k]) w_rdata = 32'(hex_q[k]);
        end
      end
    endcase
  end

  always_comb begin
    ledr_d     = ledr_q;
    ledg_d     = ledg_q;
    lcd_d      = lcd_q;
    timer_d    = timer_q + 32'd1;
    hex_d      = hex_q;
    w_edge_clr = '0;
    sw_s1_d    = i_io_sw;
    sw_s2_d    = sw_s1_q;
    btn_s1_d   = i_io_btn;
    btn_s2_d   = btn_s1_q;
    lvl_d      = lvl_q;
    cnt_d      = '0;

    if (i_wren) begin
      case (w_word)
        c_w_ledr:  ledr_d     = LEDR_W'(f_merge(32'(ledr_q), i_wdata, i_be));
        c_w_ledg:  ledg_d     = LEDG_W'(f_merge(32'(ledg_q), i_wdata, i_be));
        c_w_lcd:   lcd_d      = f_merge(lcd_q, i_wdata, i_be);
        c_w_edge:  w_edge_clr = BTN_W'(f_merge(32'd0, i_wdata, i_be));
        c_w_timer: timer_d    = f_merge(timer_q + 32'd1, i_wdata, i_be);
        default: ;
      endcase
      for (int k = 0; k < NUM_HEX; k++) begin
        if (w_hex_sel[k] && i_be[0]) hex_d[k] = i_wdata[c_hex_w-1:0];
      end
    end

    // Counter runs only while the synchronised input disagrees with the level.
    for (int b = 0; b < BTN_W; b++) begin
      if (btn_s2_q[b] != lvl_q[b]) begin
        if (cnt_q[b] == c_cnt_max) lvl_d[b] = btn_s2_q[b];
        else                       cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end

    edge_d  = (edge_q & ~w_edge_clr) | (lvl_d & ~lvl_q);
    rvld_d  = i_rden;
    rdata_d = i_rden ? w_rdata : rdata_q;
    err_d   = (i_rden || i_wren) && !w_mapped;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ledr_q   <= '0;
      ledg_q   <= '0;
      lcd_q    <= '0;
      timer_q  <= '0;
      hex_q    <= {NUM_HEX{c_hex_rst}};
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      lvl_q    <= '0;
      edge_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvld_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ledr_q   <= ledr_d;
      ledg_q   <= ledg_d;
      lcd_q    <= lcd_d;
      timer_q  <= timer_d;
      hex_q    <= hex_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      lvl_q    <= lvl_d;
      edge_q   <= edge_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvld_q   <= rvld_d;
      err_q    <= err_d;
    end
  end

  assign o_rdata   = rdata_q;
  assign o_rvld    = rvld_q;
  assign o_err     = err_q;
  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;

  for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
`ifdef HEX_DECODE_EN
    assign o_io_hex[7*k +: 7] = hex_q[k][4] ? 7'h7F : f_seg(hex_q[k][3:0]);
`else
    assign o_io_hex[7*k +: 7] = hex_q[k];
`endif
  end

endmodule
`default_nettype wire
